led_bar_indicator: RTL and testbench
====================================

Name: led_bar_indicator

Overview:
- Parametrised successor to the single-LED battery indicator.
- Drives an N-segment LED bar from battery level, charging state and fan state.
- Modes: off, solid bar, low-battery blink, and charging bar with a breathing leading segment.
- Sits between the battery/charge model and the board LED pins; all timing is derived from the system tick clock.

Parameters:
N_LED, 4, number of bar segments (1..8)
BAT_W, 8, battery input width
FULL_LEVEL, 99, battery value treated as full
LOW_THRESH, 25, battery <= this selects low-battery blink
CLK_HZ, 1000, clk frequency in Hz
BLINK_HZ, 2, low-battery blink frequency
PWM_BITS, 3, breathing PWM resolution; period is 2^PWM_BITS clk
BREATH_DIV, 8, PWM periods per breathing duty step (>=1)
LOW_HYST, 3, hysteresis width used only with LED_LOW_HYST_EN

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
battery  in  BAT_W  current charge level, 0..FULL_LEVEL; larger values treated as full
charging  in  1  1 = charger connected
fan_state  in  2  0 = fan idle, nonzero = running
led  out  N_LED  1 = segment lit; led[0] is the bottom segment
mode_o  out  3  current mode encoding, for debug and verification

Behaviour:
- Reset: clk and rst_n as stated; rst_n is asynchronous and active-low. All of the following take effect immediately on assertion:
  - led = 0 and mode_o = M_OFF.
  - Blink, PWM and breath counters = 0; breath direction = up.
- Segment thresholds: T_i = (i*FULL_LEVEL)/N_LED, integer, elaboration-time constant.
  - Bar mask: bar[i] = (battery > T_i).
  - lead = index of the lowest unlit segment, or N_LED if all segments are lit.
- Mode priority, evaluated every clk and registered into mode_o:
  - M_OFF (0): fan_state == 0.
  - M_FULL (1): battery >= FULL_LEVEL.
  - M_CHARGE (2): charging.
  - M_LOW (3): battery <= LOW_THRESH.
  - M_NORMAL (4): otherwise.
- Latency: a change on an input is visible on mode_o 1 clk later and on led 2 clk later. led is fully registered.
- Per-mode output:
  - M_OFF: led = 0.
  - M_FULL: led = all ones.
  - M_NORMAL: led = bar.
  - M_LOW: led[0] = blink phase; all other segments 0.
  - M_CHARGE: led = bar, with led[lead] = PWM output when lead < N_LED.
- Blink:
  - Half-period HP = CLK_HZ/(2*BLINK_HZ) clk (default 250).
  - Counter runs 0..HP-1 and toggles the phase at HP-1.
  - On entry into M_LOW, the counter clears and the phase is set to 1, so the LED is on first.
- Breathing:
  - pwm_cnt is a free-running PWM_BITS-bit counter; it wraps at all ones.
  - PWM output is (pwm_cnt < duty). Duty 0 means never lit; duty 2^PWM_BITS-1 means lit for all but one clk.
  - step_cnt counts completed PWM periods (pwm_cnt wrap) from 0 to BREATH_DIV-1.
  - When step_cnt wraps, duty moves one step:
    - Direction up: duty increments; at max duty the direction flips to down and duty holds for that step.
    - Direction down: duty decrements; at 0 the direction flips to up and duty holds.
  - On entry into M_CHARGE: duty = 0, direction = up, step_cnt = 0. pwm_cnt keeps running.
- Mode change mid-blink or mid-breath takes effect on the next registered cycle; no phase is carried over except pwm_cnt.
- Simultaneous events: charging and battery >= FULL_LEVEL gives M_FULL. Fan idle overrides everything.
- battery = 0 and not charging gives M_LOW. battery = 0 and charging gives M_CHARGE with lead = 0.

Optional Feature:
LED_LOW_HYST_EN
- Defined:
  - Entry into M_LOW requires battery <= LOW_THRESH.
  - While in M_LOW, the block stays in M_LOW until battery > LOW_THRESH+LOW_HYST, or until a higher-priority condition occurs.
  - A sticky low_latched flag, cleared by reset, tracks this.
- Undefined: no hysteresis; M_LOW is entered and left purely on battery <= LOW_THRESH.

Decomposition:
- Shared package (led_pkg): mode encodings M_OFF..M_NORMAL, MODE_W = 3, and a threshold-calculation function.
- Natural sub-module: led_breath_pwm, which holds the PWM counter, step counter, duty and direction.
  - Inputs: clk, rst_n, restart.
  - Output: pwm_out.
  - Parameters: PWM_BITS, BREATH_DIV.
- Blink, mode FSM and bar logic stay in the top module.

Test Plan (defaults unless stated; thresholds 0, 24, 49, 74):
- Reset asserted mid-breath with battery=40, charging=1 -> led=0 and mode_o=0 immediately; same mode resumes 1 clk after release with duty=0.
- fan_state=1, battery=50, charging=0 -> mode_o=4 after 1 clk, led=4'b0111 after 2 clk; battery=99 -> led=4'b1111, mode_o=1.
- battery=20, charging=0 -> led[0] high for 250 clk, then low for 250 clk, repeating; led[3:1]=0. Set fan_state=0 -> led=0 within 2 clk.
- battery=60, charging=1, PWM_BITS=3, BREATH_DIV=8 -> led[2:0]=3'b111; led[3] duty follows 0,1..7,7,6..0,0 with each step lasting 64 clk. Full up-down cycle = 1024 clk.
- Boundaries: battery=24 -> bar 4'b0001 (mode low, blink instead); battery=25 -> low; battery=26 -> normal, led=4'b0011. battery=255 -> M_FULL.
- With LED_LOW_HYST_EN: sweep battery 20->26->28->29 -> stays in M_LOW through 28, goes to M_NORMAL at 29. Without the macro, 26 already gives M_NORMAL.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Mode encodings and segment-threshold helper for the LED bar.
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        M_OFF    = 3'd0,
        M_FULL   = 3'd1,
        M_CHARGE = 3'd2,
        M_LOW    = 3'd3,
        M_NORMAL = 3'd4
    } mode_e;

    // Segment idx lights once the battery level is strictly above this value.
    function automatic int seg_thresh(input int idx, input int full_level, input int n_led);
        return (idx * full_level) / n_led;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_breath_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_breath_pwm
// Purpose  : Triangle-wave breathing PWM for the leading charge segment.
// Revision : 1.0 - initial release
// ============================================================================
module led_breath_pwm #(
    parameter int PWM_BITS   = 3,
    parameter int BREATH_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic pwm_out
);

    localparam int                  c_step_w    = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
    localparam logic [PWM_BITS-1:0] c_duty_max  = '1;
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(BREATH_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [c_step_w-1:0] step_cnt_q;
    logic                dir_down_q;
    logic                period_end;

    assign period_end = (pwm_cnt_q == c_duty_max);
    assign pwm_out    = (pwm_cnt_q < duty_q);

    // The PWM counter never restarts so a mode change leaves its phase intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            step_cnt_q <= '0;
            dir_down_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (restart) begin
                duty_q     <= '0;
                step_cnt_q <= '0;
                dir_down_q <= 1'b0;
            end else if (period_end) begin
                if (step_cnt_q == c_step_last) begin
                    step_cnt_q <= '0;
                    if (!dir_down_q) begin
                        if (duty_q == c_duty_max) begin
                            dir_down_q <= 1'b1;
                        end else begin
                            duty_q <= duty_q + 1'b1;
                        end
                    end else begin
                        if (duty_q == '0) begin
                            dir_down_q <= 1'b0;
                        end else begin
                            duty_q <= duty_q - 1'b1;
                        end
                    end
                end else begin
                    step_cnt_q <= step_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_bar_indicator.sv
`default_nettype none
// ============================================================================
// Module   : led_bar_indicator
// Purpose  : N-segment battery bar with low blink and breathing charge segment.
//            Define LED_LOW_HYST_EN to add exit hysteresis to low-battery mode.
// Revision : 1.0 - initial release
// ============================================================================
module led_bar_indicator
    import led_pkg::*;
#(
    parameter int N_LED      = 4,
    parameter int BAT_W      = 8,
    parameter int FULL_LEVEL = 99,
    parameter int LOW_THRESH = 25,
    parameter int CLK_HZ     = 1000,
    parameter int BLINK_HZ   = 2,
    parameter int PWM_BITS   = 3,
    parameter int BREATH_DIV = 8,
    parameter int LOW_HYST   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BAT_W-1:0]  battery,
    input  logic              charging,
    input  logic [1:0]        fan_state,
    output logic [N_LED-1:0]  led,
    output logic [MODE_W-1:0] mode_o
);

    localparam int                   c_half_period = CLK_HZ / (2 * BLINK_HZ);
    localparam int                   c_blink_w     = (c_half_period > 1) ? $clog2(c_half_period) : 1;
    localparam int                   c_lead_w      = $clog2(N_LED + 1);
    localparam logic [c_blink_w-1:0] c_blink_last  = c_blink_w'(c_half_period - 1);

    mode_e                mode_d, mode_q;
    logic [N_LED-1:0]     bar_d, bar_q;
    logic [c_lead_w-1:0]  lead_d, lead_q;
    logic [N_LED-1:0]     led_d, led_q;
    logic [c_blink_w-1:0] blink_cnt_q;
    logic                 blink_q;
    logic                 low_entry;
    logic                 charge_entry;
    logic                 pwm_out;
    logic                 low_latched;
    logic [31:0]          bat_ext;

    assign bat_ext = 32'(battery);

`ifdef LED_LOW_HYST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_latched <= 1'b0;
        end else begin
            low_latched <= (mode_d == M_LOW);
        end
    end
`else
    assign low_latched = 1'b0;
`endif

    always_comb begin
        bar_d = '0;
        for (int i = 0; i < N_LED; i++) begin
            bar_d[i] = (bat_ext > 32'(seg_thresh(i, FULL_LEVEL, N_LED)));
        end
        lead_d = c_lead_w'(N_LED);
        for (int i = N_LED - 1; i >= 0; i--) begin
            if (!bar_d[i]) begin
                lead_d = c_lead_w'(i);
            end
        end
    end

    always_comb begin
        mode_d = M_NORMAL;
        if (fan_state == 2'b00) begin
            mode_d = M_OFF;
        end else if (bat_ext >= 32'(FULL_LEVEL)) begin
            mode_d = M_FULL;
        end else if (charging) begin
            mode_d = M_CHARGE;
        end else if ((bat_ext <= 32'(LOW_THRESH)) ||
                     (low_latched && (bat_ext <= 32'(LOW_THRESH + LOW_HYST)))) begin
            mode_d = M_LOW;
        end
    end

    assign low_entry    = (mode_d == M_LOW)    && (mode_q != M_LOW);
    assign charge_entry = (mode_d == M_CHARGE) && (mode_q != M_CHARGE);

    led_breath_pwm #(
        .PWM_BITS   (PWM_BITS),
        .BREATH_DIV (BREATH_DIV)
    ) u_breath (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (charge_entry),
        .pwm_out (pwm_out)
    );

    always_comb begin
        led_d = '0;
        case (mode_q)
            M_FULL:   led_d = '1;
            M_NORMAL: led_d = bar_q;
            M_LOW:    led_d[0] = blink_q;
            M_CHARGE: begin
                led_d = bar_q;
                for (int i = 0; i < N_LED; i++) begin
                    if (lead_q == c_lead_w'(i)) begin
                        led_d[i] = pwm_out;
                    end
                end
            end
            default:  led_d = '0;
        endcase
    end

    // Mode, bar and blink state form stage one; led is the second register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= M_OFF;
            bar_q       <= '0;
            lead_q      <= '0;
            led_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            mode_q <= mode_d;
            bar_q  <= bar_d;
            lead_q <= lead_d;
            led_q  <= led_d;
            if (low_entry) begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b1;
            end else if (mode_q == M_LOW) begin
                if (blink_cnt_q == c_blink_last) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    assign led    = led_q;
    assign mode_o = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_bar_indicator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_led_bar_indicator
// Purpose  : Directed scoreboard bench for led_bar_indicator at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_bar_indicator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] battery;
    logic       charging;
    logic [1:0] fan_state;
    logic [3:0] led;
    logic [2:0] mode_o;

`ifdef LED_LOW_HYST_EN
    localparam logic [2:0] c_hyst_mode = 3'd3;
`else
    localparam logic [2:0] c_hyst_mode = 3'd4;
`endif

    always #5 clk = ~clk;

    led_bar_indicator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .battery   (battery),
        .charging  (charging),
        .fan_state (fan_state),
        .led       (led),
        .mode_o    (mode_o)
    );

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic [2:0] mode;
        bit         ck_led;
        bit         ck_mode;
    } exp_t;

    exp_t sb_q[$];
    int   pulse_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] bat, input logic chg, input logic [1:0] fan);
        battery   = bat;
        charging  = chg;
        fan_state = fan;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] l, input logic [2:0] m,
                              input bit cl, input bit cm);
        exp_t e;
        e.tag     = tag;
        e.led     = l;
        e.mode    = m;
        e.ck_led  = cl;
        e.ck_mode = cm;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        if (e.ck_mode) chk({e.tag, "_mode"}, 32'(mode_o), 32'(e.mode));
        if (e.ck_led)  chk({e.tag, "_led"},  32'(led),    32'(e.led));
    endtask

    task automatic step(input string tag, input int n, input logic [3:0] l, input logic [2:0] m,
                        input bit cl, input bit cm);
        expect_out(tag, l, m, cl, cm);
        clks(n);
        check_out();
    endtask

    task automatic wait_rise(input int budget, output bit ok, output int waited);
        ok     = 1'b0;
        waited = 0;
        while (waited < budget) begin
            if (led[3]) begin
                ok = 1'b1;
                return;
            end
            clks(1);
            waited++;
        end
    endtask

    // Each high pulse on the leading segment lasts exactly the current duty.
    task automatic breath_pulses();
        bit ok;
        int waited;
        int len;
        wait_rise(200, ok, waited);
        chk("breath_first_rise", 32'(ok), 32'd1);
        for (int k = 0; k < 112 && ok; k++) begin
            len = 0;
            while (led[3] && len < 16) begin
                clks(1);
                len++;
            end
            chk($sformatf("pulse%0d_len", k), 32'(len), 32'(pulse_q.pop_front()));
            if (k < 111) begin
                wait_rise(16, ok, waited);
                chk($sformatf("pulse%0d_period", k), 32'(len + waited), 32'd8);
            end else begin
                wait_rise(200, ok, waited);
                chk("zero_duty_gap", 32'(len + waited), 32'd136);
            end
        end
        if (!ok) chk("breath_rise_found", 32'(ok), 32'd1);
    endtask

    initial begin
        int highs;
        rst_n = 1'b1;
        drive(8'd0, 1'b0, 2'd0);
        #3 rst_n = 1'b0;
        #1;
        expect_out("reset", 4'b0000, 3'd0, 1'b1, 1'b1);
        check_out();
        clks(3);
        rst_n = 1'b1;
        step("idle", 2, 4'b0000, 3'd0, 1'b1, 1'b1);

        drive(8'd50, 1'b0, 2'd1);
        step("normal50_m", 1, 4'b0000, 3'd4, 1'b0, 1'b1);
        step("normal50",   1, 4'b0111, 3'd4, 1'b1, 1'b1);
        drive(8'd99, 1'b0, 2'd1);
        step("full99", 2, 4'b1111, 3'd1, 1'b1, 1'b1);
        drive(8'd26, 1'b0, 2'd1);
        step("normal26", 2, 4'b0011, 3'd4, 1'b1, 1'b1);
        drive(8'd25, 1'b0, 2'd1);
        step("low25", 2, 4'b0001, 3'd3, 1'b1, 1'b1);
        drive(8'd24, 1'b0, 2'd1);
        step("low24", 2, 4'b0001, 3'd3, 1'b1, 1'b1);
        drive(8'd0, 1'b0, 2'd1);
        step("low0", 2, 4'b0001, 3'd3, 1'b1, 1'b1);
        drive(8'd255, 1'b0, 2'd1);
        step("full255", 2, 4'b1111, 3'd1, 1'b1, 1'b1);

        drive(8'd20, 1'b0, 2'd1);
        step("blink_on_first", 2,   4'b0001, 3'd3, 1'b1, 1'b1);
        step("blink_on_last",  249, 4'b0001, 3'd3, 1'b1, 1'b1);
        step("blink_off_first",1,   4'b0000, 3'd3, 1'b1, 1'b1);
        step("blink_off_last", 249, 4'b0000, 3'd3, 1'b1, 1'b1);
        step("blink_on_again", 1,   4'b0001, 3'd3, 1'b1, 1'b1);
        drive(8'd20, 1'b0, 2'd0);
        step("fan_idle", 2, 4'b0000, 3'd0, 1'b1, 1'b1);

        drive(8'd20, 1'b0, 2'd1);
        step("hyst20", 1, 4'b0000, 3'd3, 1'b0, 1'b1);
        drive(8'd26, 1'b0, 2'd1);
        step("hyst26", 1, 4'b0000, c_hyst_mode, 1'b0, 1'b1);
        drive(8'd28, 1'b0, 2'd1);
        step("hyst28", 1, 4'b0000, c_hyst_mode, 1'b0, 1'b1);
        drive(8'd29, 1'b0, 2'd1);
        step("hyst29", 1, 4'b0000, 3'd4, 1'b0, 1'b1);

        drive(8'd0, 1'b1, 2'd1);
        step("charge0", 2, 4'b0000, 3'd2, 1'b1, 1'b1);
        drive(8'd99, 1'b1, 2'd1);
        step("charge_full", 2, 4'b1111, 3'd1, 1'b1, 1'b1);

        drive(8'd60, 1'b1, 2'd1);
        for (int d = 1; d <= 6; d++) repeat (8) pulse_q.push_back(d);
        repeat (16) pulse_q.push_back(7);
        for (int d = 6; d >= 1; d--) repeat (8) pulse_q.push_back(d);
        step("breath_start", 2, 4'b0111, 3'd2, 1'b1, 1'b1);
        breath_pulses();
        chk("breath_bar", 32'(led[2:0]), 32'h7);

        drive(8'd40, 1'b1, 2'd1);
        clks(100);
        rst_n = 1'b0;
        #2;
        expect_out("rst_async", 4'b0000, 3'd0, 1'b1, 1'b1);
        check_out();
        step("rst_hold", 2, 4'b0000, 3'd0, 1'b1, 1'b1);
        rst_n = 1'b1;
        step("rst_resume_m", 1, 4'b0000, 3'd2, 1'b0, 1'b1);
        step("rst_resume",   1, 4'b0011, 3'd2, 1'b1, 1'b1);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            if (led[2]) highs++;
            clks(1);
        end
        chk("rst_duty_zero", 32'(highs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
